pac_flash_writeback: RTL and testbench

//  Writes the PAC SRAM image from SD-RAM (RAM_BASE) back to its FLASH home (FLASH_BASE), so PAC saves persist across power cycles.

---
 rtl/pac_flash_writeback.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pac_flash_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pac_flash_writeback.sv
// pac_flash_writeback: copies the PAC SRAM image from SD-RAM (RAM_BASE) back to
// its FLASH home (FLASH_BASE), one sector erase pass followed by page programs.
// Optional read-back verify pass: define PAC_WRITEBACK_VERIFY_EN.
//
// Handshake (both ports): a request (RAM_RD / FL_REQ) and its address/command/
// data are registered and held stable until the matching ACK. The cycle in which
// request and ACK are both high completes exactly one transaction. If the request
// is still high in the following cycle, that is a new transaction (back-to-back
// FLASH commands such as ERASE->ERASE or ERASE->PAGE_BEGIN). An ACK seen while
// its own request is low is ignored. RAM_RD and FL_REQ are never high together.
module pac_flash_writeback #(
  parameter logic [23:0] RAM_BASE   = 24'h77_E000,
  parameter logic [23:0] FLASH_BASE = 24'h1F_0000,
  parameter logic [23:0] SIZE       = 24'h00_2000,
  parameter int unsigned SECTOR     = 4096,
  parameter int unsigned PAGE       = 256
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [23:0] RAM_ADDR,
  output logic        RAM_RD,
  input  logic        RAM_ACK,
  input  logic [7:0]  RAM_RDATA,
  output logic [2:0]  FL_CMD,
  output logic [23:0] FL_ADDR,
  output logic [7:0]  FL_WDATA,
  output logic        FL_REQ,
  input  logic        FL_ACK,
  input  logic [7:0]  FL_RDATA,
  input  logic        FL_ERR,
  output logic [3:0]  DBG_STATE
);

  localparam logic [23:0] SECTOR24  = 24'(SECTOR);
  localparam logic [23:0] PAGE24    = 24'(PAGE);
  localparam logic [23:0] PAGE_MASK = 24'(PAGE - 1);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_ERASE  = 3'd1;
  localparam logic [2:0] CMD_PBEGIN = 3'd2;
  localparam logic [2:0] CMD_PDATA  = 3'd3;
  localparam logic [2:0] CMD_PEND   = 3'd4;
`ifdef PAC_WRITEBACK_VERIFY_EN
  localparam logic [2:0] CMD_READ   = 3'd5;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ERASE  = 4'd1,
    S_PBEGIN = 4'd2,
    S_RDRAM  = 4'd3,
    S_PDATA  = 4'd4,
    S_PEND   = 4'd5,
`ifdef PAC_WRITEBACK_VERIFY_EN
    S_VRD    = 4'd6,   // verify: fetch reference byte from SD-RAM
    S_VFL    = 4'd7,   // verify: read FLASH byte and compare
`endif
    S_FIN    = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] off_q, off_d;
  logic        err_q, err_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ram_rd_q, ram_rd_d;
  logic        fl_req_q, fl_req_d;
  logic [2:0]  fl_cmd_q, fl_cmd_d;
  logic [23:0] fl_addr_q, fl_addr_d;
  logic [23:0] ram_addr_q, ram_addr_d;
  logic [23:0] off_inc, off_sec;
  logic        fl_done, ram_done;

  // Only acks that answer an outstanding request move the FSM.
  assign fl_done  = FL_ACK & fl_req_q;
  assign ram_done = RAM_ACK & ram_rd_q;
  assign off_inc  = off_q + 24'd1;
  assign off_sec  = off_q + SECTOR24;

`ifdef PAC_WRITEBACK_VERIFY_EN
  logic [7:0] vbyte_q, vbyte_d;
`else
  logic unused_rdata;
  assign unused_rdata = ^FL_RDATA;
`endif

  // Next-state, offset, error and write-data sequencing.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    err_d   = err_q;
    wdata_d = wdata_q;
`ifdef PAC_WRITEBACK_VERIFY_EN
    vbyte_d = vbyte_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          err_d   = 1'b0;
          off_d   = 24'd0;
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        if (fl_done) begin
          if (FL_ERR) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (off_sec == SIZE) begin
            off_d   = 24'd0;
            state_d = S_PBEGIN;
          end else begin
            off_d   = off_sec;
          end
        end
      end
      S_PBEGIN: begin
        if (fl_done) begin
          if (FL_ERR) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_RDRAM;
          end
        end
      end
      S_RDRAM: begin
        if (ram_done) begin
          wdata_d = RAM_RDATA;
          state_d = S_PDATA;
        end
      end
      S_PDATA: begin
        if (fl_done) begin
          if (FL_ERR) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            off_d   = off_inc;
            state_d = ((off_inc & PAGE_MASK) == 24'd0) ? S_PEND : S_RDRAM;
          end
        end
      end
      S_PEND: begin
        if (fl_done) begin
          if (FL_ERR) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (off_q == SIZE) begin
`ifdef PAC_WRITEBACK_VERIFY_EN
            off_d   = 24'd0;
            state_d = S_VRD;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_PBEGIN;
          end
        end
      end
`ifdef PAC_WRITEBACK_VERIFY_EN
      S_VRD: begin
        if (ram_done) begin
          vbyte_d = RAM_RDATA;
          state_d = S_VFL;
        end
      end
      S_VFL: begin
        if (fl_done) begin
          if (FL_ERR || (FL_RDATA != vbyte_q)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            off_d   = off_inc;
            state_d = (off_inc == SIZE) ? S_FIN : S_VRD;
          end
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered port values decoded from the state being entered, so a request
  // rises in the first cycle of its state and falls right after its ack.
  always_comb begin
    fl_req_d   = 1'b0;
    ram_rd_d   = 1'b0;
    fl_cmd_d   = CMD_NOP;
    fl_addr_d  = fl_addr_q;
    ram_addr_d = ram_addr_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    case (state_d)
      S_ERASE: begin
        fl_req_d  = 1'b1;
        fl_cmd_d  = CMD_ERASE;
        fl_addr_d = FLASH_BASE + off_d;
      end
      S_PBEGIN: begin
        fl_req_d  = 1'b1;
        fl_cmd_d  = CMD_PBEGIN;
        fl_addr_d = FLASH_BASE + off_d;
      end
      S_RDRAM: begin
        ram_rd_d   = 1'b1;
        ram_addr_d = RAM_BASE + off_d;
      end
      S_PDATA: begin
        fl_req_d  = 1'b1;
        fl_cmd_d  = CMD_PDATA;
        fl_addr_d = FLASH_BASE + off_d;
      end
      S_PEND: begin
        // Offset already points past the page; report the page's own base.
        fl_req_d  = 1'b1;
        fl_cmd_d  = CMD_PEND;
        fl_addr_d = FLASH_BASE + off_d - PAGE24;
      end
`ifdef PAC_WRITEBACK_VERIFY_EN
      S_VRD: begin
        ram_rd_d   = 1'b1;
        ram_addr_d = RAM_BASE + off_d;
      end
      S_VFL: begin
        fl_req_d  = 1'b1;
        fl_cmd_d  = CMD_READ;
        fl_addr_d = FLASH_BASE + off_d;
      end
`endif
      default: ;
    endcase
  end

  // State and output registers; reset aborts any transfer at once.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      off_q      <= 24'd0;
      err_q      <= 1'b0;
      wdata_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_rd_q   <= 1'b0;
      fl_req_q   <= 1'b0;
      fl_cmd_q   <= CMD_NOP;
      fl_addr_q  <= FLASH_BASE;
      ram_addr_q <= RAM_BASE;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_rd_q   <= ram_rd_d;
      fl_req_q   <= fl_req_d;
      fl_cmd_q   <= fl_cmd_d;
      fl_addr_q  <= fl_addr_d;
      ram_addr_q <= ram_addr_d;
    end
  end

`ifdef PAC_WRITEBACK_VERIFY_EN
  // Reference byte captured during the verify pass.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) vbyte_q <= 8'd0;
    else          vbyte_q <= vbyte_d;
  end
`endif

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RAM_RD    = ram_rd_q;
  assign RAM_ADDR  = ram_addr_q;
  assign FL_REQ    = fl_req_q;
  assign FL_CMD    = fl_cmd_q;
  assign FL_ADDR   = fl_addr_q;
  assign FL_WDATA  = wdata_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pac_flash_writeback.sv
// tb_pac_flash_writeback: directed bench for pac_flash_writeback.
// The DUT is built with a scaled geometry (SECTOR=256, PAGE=16, SIZE=512) that
// keeps the same shape as the production image: 2 sectors, 32 pages.
// Expected command stream is generated from the copy rules; RAM byte at address
// a is a[7:0]^8'h5A; a FLASH model stores programmed bytes.
module tb_pac_flash_writeback;

  localparam logic [23:0] RB  = 24'h77_E000;
  localparam logic [23:0] FB  = 24'h1F_0000;
  localparam int          SZ  = 512;
  localparam int          SEC = 256;
  localparam int          PG  = 16;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  always #5 CLK = ~CLK;

  logic        START = 1'b0;
  logic        RAM_ACK = 1'b0, FL_ACK = 1'b0, FL_ERR = 1'b0;
  logic [7:0]  RAM_RDATA = 8'd0, FL_RDATA = 8'd0;
  logic        BUSY, DONE, ERR, RAM_RD, FL_REQ;
  logic [23:0] RAM_ADDR, FL_ADDR;
  logic [2:0]  FL_CMD;
  logic [7:0]  FL_WDATA;
  logic [3:0]  DBG_STATE;

  pac_flash_writeback #(
    .RAM_BASE(RB), .FLASH_BASE(FB), .SIZE(24'(SZ)), .SECTOR(SEC), .PAGE(PG)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RAM_ADDR(RAM_ADDR), .RAM_RD(RAM_RD), .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA),
    .FL_CMD(FL_CMD), .FL_ADDR(FL_ADDR), .FL_WDATA(FL_WDATA), .FL_REQ(FL_REQ),
    .FL_ACK(FL_ACK), .FL_RDATA(FL_RDATA), .FL_ERR(FL_ERR), .DBG_STATE(DBG_STATE)
  );

  // scoreboard: {chk_wdata, chk_addr, cmd, addr, wdata}
  logic [36:0] exp_q[$];
  logic [23:0] exp_ram_q[$];
  int n_vec = 0, n_err = 0;

  // models and responder state
  logic [7:0]  flash_img [0:SZ-1];
  int          max_dly = 0;
  int          err_idx = -1, bad_idx = -1;
  int          stray_req = 0, stray_done = 0;
  int          done_cnt = 0, n_er = 0, n_pb = 0, n_pe = 0, n_rd = 0;
  bit          fl_busy = 0, ram_busy = 0, first_pending = 0;
  int          fl_cnt = 0, ram_cnt = 0;
  logic [2:0]  cap_cmd;
  logic [23:0] cap_addr, cap_raddr, first_addr;
  logic [7:0]  cap_wd;

  function automatic logic [7:0] ram_byte(input logic [23:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_fl(input logic [2:0] c, input int off, input logic [7:0] wd,
                         input bit ca, input bit cw);
    exp_q.push_back({cw, ca, c, 24'(FB + 24'(off)), wd});
  endtask

  // Expected command stream for one accepted START.
  task automatic build_expected(input int err_off, input int bad_off);
    logic [23:0] ra;
    exp_q.delete();
    exp_ram_q.delete();
    for (int s = 0; s < SZ / SEC; s++) push_fl(3'd1, s * SEC, 8'd0, 1, 0);
    for (int off = 0; off < SZ; off++) begin
      if (off % PG == 0) push_fl(3'd2, off, 8'd0, 1, 0);
      ra = 24'(RB + 24'(off));
      exp_ram_q.push_back(ra);
      push_fl(3'd3, off, ram_byte(ra), 1, 1);
      if (off == err_off) return;
      if (off % PG == PG - 1) push_fl(3'd4, off, 8'd0, 0, 0);
    end
`ifdef PAC_WRITEBACK_VERIFY_EN
    for (int off = 0; off < SZ; off++) begin
      exp_ram_q.push_back(24'(RB + 24'(off)));
      push_fl(3'd5, off, 8'd0, 1, 0);
      if (off == bad_off) return;
    end
`else
    if (bad_off >= 0) $display("note: verify pass not built, bad_off unused");
`endif
  endtask

  // Per-cycle compare and port responder, run at every falling edge.
  task automatic respond();
    logic [36:0] e;
    int idx;
    FL_ACK = 1'b0; FL_ERR = 1'b0; RAM_ACK = 1'b0;
    if (!RESET_n) begin
      fl_busy = 0; ram_busy = 0;
      return;
    end
    check("excl_req", {39'd0, RAM_RD & FL_REQ}, 40'd0);
    if (DONE) begin
      done_cnt++;
      check("busy_at_done", {39'd0, BUSY}, 40'd1);
    end
    // FLASH port
    if (fl_busy) begin
      if (!FL_REQ) begin
        check("fl_req_drop", {39'd0, FL_REQ}, 40'd1);
        fl_busy = 0;
      end else begin
        check("fl_hold", {5'd0, FL_CMD, FL_ADDR, FL_WDATA}, {5'd0, cap_cmd, cap_addr, cap_wd});
        if (fl_cnt == 0) begin
          idx = int'(cap_addr - FB);
          case (cap_cmd)
            3'd1: begin n_er++; for (int i = 0; i < SEC; i++) flash_img[(idx + i) % SZ] = 8'hFF; end
            3'd2: n_pb++;
            3'd3: if (idx == err_idx) begin FL_ERR = 1'b1; err_idx = -1; end
                  else flash_img[idx % SZ] = (idx == bad_idx) ? ~cap_wd : cap_wd;
            3'd4: n_pe++;
            3'd5: begin n_rd++; FL_RDATA = flash_img[idx % SZ]; end
            default: ;
          endcase
          FL_ACK = 1'b1;
          fl_busy = 0;
        end else fl_cnt--;
      end
    end else if (FL_REQ) begin
      fl_busy = 1;
      fl_cnt = $urandom_range(0, max_dly);
      cap_cmd = FL_CMD; cap_addr = FL_ADDR; cap_wd = FL_WDATA;
      if (first_pending) begin first_addr = FL_ADDR; first_pending = 0; end
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL fl_unexpected: got cmd %0d addr %0h want no request", FL_CMD, FL_ADDR);
      end else begin
        e = exp_q.pop_front();
        check("fl_cmd", {37'd0, FL_CMD}, {37'd0, e[34:32]});
        if (e[35]) check("fl_addr", {16'd0, FL_ADDR}, {16'd0, e[31:8]});
        if (e[36]) check("fl_wdata", {32'd0, FL_WDATA}, {32'd0, e[7:0]});
      end
    end
    // RAM port
    if (ram_busy) begin
      if (!RAM_RD) begin
        check("ram_rd_drop", {39'd0, RAM_RD}, 40'd1);
        ram_busy = 0;
      end else begin
        check("ram_hold", {16'd0, RAM_ADDR}, {16'd0, cap_raddr});
        if (ram_cnt == 0) begin
          RAM_RDATA = ram_byte(cap_raddr);
          RAM_ACK = 1'b1;
          ram_busy = 0;
        end else ram_cnt--;
      end
    end else if (RAM_RD) begin
      ram_busy = 1;
      ram_cnt = $urandom_range(0, max_dly);
      cap_raddr = RAM_ADDR;
      if (exp_ram_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ram_unexpected: got %0h want no request", RAM_ADDR);
      end else check("ram_addr", {16'd0, RAM_ADDR}, {16'd0, exp_ram_q.pop_front()});
    end
    // stray acks, only while nothing is outstanding
    if (stray_req > stray_done && !FL_REQ && !RAM_RD) begin
      FL_ACK = 1'b1; RAM_ACK = 1'b1; FL_ERR = 1'b1;
      stray_done++;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    respond();
  endtask

  task automatic start_pulse();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_busy"},  {39'd0, BUSY},   40'd0);
    check({p, "_done"},  {39'd0, DONE},   40'd0);
    check({p, "_err"},   {39'd0, ERR},    40'd0);
    check({p, "_ramrd"}, {39'd0, RAM_RD}, 40'd0);
    check({p, "_flreq"}, {39'd0, FL_REQ}, 40'd0);
    check({p, "_flcmd"}, {37'd0, FL_CMD}, 40'd0);
    check({p, "_raddr"}, {16'd0, RAM_ADDR}, {16'd0, RB});
    check({p, "_faddr"}, {16'd0, FL_ADDR},  {16'd0, FB});
    check({p, "_wdata"}, {32'd0, FL_WDATA}, 40'd0);
  endtask

  task automatic wait_done(input string nm);
    int d0, i;
    d0 = done_cnt; i = 0;
    while (done_cnt == d0 && i < 20000) begin tick(); i++; end
    check({nm, "_done_seen"}, {39'd0, done_cnt != d0}, 40'd1);
    tick(); tick();
  endtask

  task automatic image_check(input string nm);
    int mism;
    mism = 0;
    for (int i = 0; i < SZ; i++)
      if (flash_img[i] !== ram_byte(24'(RB + 24'(i)))) mism++;
    check({nm, "_image"}, 40'(mism), 40'd0);
  endtask

  // One accepted START through to DONE.
  task automatic run_one(input string nm, input int dly, input int err_off,
                         input int bad_off, input logic exp_err);
    int d0;
    max_dly = dly;
    build_expected(err_off, bad_off);
    d0 = done_cnt;
    first_pending = 1;
    start_pulse();
    check({nm, "_busy_on"}, {39'd0, BUSY}, 40'd1);
    check({nm, "_err_clr"}, {39'd0, ERR},  40'd0);
    wait_done(nm);
    check({nm, "_done_once"}, 40'(done_cnt - d0), 40'd1);
    check({nm, "_err"},  {39'd0, ERR},  {39'd0, exp_err});
    check({nm, "_busy_off"}, {39'd0, BUSY}, 40'd0);
    check({nm, "_fl_left"},  40'(exp_q.size()), 40'd0);
    check({nm, "_ram_left"}, 40'(exp_ram_q.size()), 40'd0);
    check({nm, "_first"}, {16'd0, first_addr}, {16'd0, FB});
    if (!exp_err) image_check(nm);
  endtask

  int er0, pb0, pe0, d0;
  initial begin
    // reset
    RESET_n = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    RESET_n = 1'b1;
    tick();

    // 1: zero-wait full copy, with hand-computed pins
    er0 = n_er; pb0 = n_pb; pe0 = n_pe;
    run_one("zw", 0, -1, -1, 1'b0);
    check("zw_erase_cnt",  40'(n_er - er0), 40'd2);
    check("zw_pbegin_cnt", 40'(n_pb - pb0), 40'd32);
    check("zw_pend_cnt",   40'(n_pe - pe0), 40'd32);
    check("zw_byte_123",   {32'd0, flash_img[9'h123]}, 40'h79);
    check("zw_byte_000",   {32'd0, flash_img[9'h000]}, 40'h5A);

    // 2: random 0-7 cycle ack delays on both ports
    run_one("rnd", 7, -1, -1, 1'b0);

    // 3: FL_ERR on 5th PAGE_DATA of page 3, then a clean rerun
    err_idx = 3 * PG + 4;
    run_one("ferr", 2, 3 * PG + 4, -1, 1'b1);
    run_one("ferr_rerun", 1, -1, -1, 1'b0);

    // 4: stray acks in IDLE and START re-pulses while busy
    stray_req = stray_req + 3;
    repeat (8) tick();
    check("stray_busy",  {39'd0, BUSY},   40'd0);
    check("stray_err",   {39'd0, ERR},    40'd0);
    check("stray_flreq", {39'd0, FL_REQ}, 40'd0);
    check("stray_acks",  40'(stray_done), 40'd3);
    max_dly = 1;
    build_expected(-1, -1);
    d0 = done_cnt;
    start_pulse();
    repeat (20) tick();
    start_pulse();
    repeat (300) tick();
    start_pulse();
    wait_done("restart");
    repeat (20) tick();
    check("restart_done_once", 40'(done_cnt - d0), 40'd1);
    check("restart_fl_left",   40'(exp_q.size()), 40'd0);
    image_check("restart");

    // 5: async reset during page 10 PAGE_DATA, then restart from ERASE
    max_dly = 0;
    build_expected(-1, -1);
    start_pulse();
    for (int i = 0; i < 5000 && !(FL_REQ && FL_CMD == 3'd3 && FL_ADDR == 24'(FB + 24'(10 * PG))); i++)
      tick();
    check("p10_reached", {16'd0, FL_ADDR}, {16'd0, 24'(FB + 24'(10 * PG))});
    #2 RESET_n = 1'b0;
    #1 check_reset_vals("arst");
    repeat (3) tick();
    RESET_n = 1'b1;
    exp_q.delete();
    exp_ram_q.delete();
    repeat (3) tick();
    check_reset_vals("post_rst");
    run_one("after_rst", 3, -1, -1, 1'b0);

`ifdef PAC_WRITEBACK_VERIFY_EN
    // 6: FLASH corrupts one byte on program; verify stops at it
    bad_idx = 9'h134;
    run_one("vfy_bad", 1, -1, 9'h134, 1'b1);
    bad_idx = -1;
    run_one("vfy_clean", 0, -1, -1, 1'b0);
`else
    // 6: no READ command is ever issued without the verify pass
    check("no_read_cmd", 40'(n_rd), 40'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
